uart_tx_sched: RTL

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rr_arb.sv | 31 +++
 rtl/uart_tx_sched.sv | 130 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared state encoding and word/byte helpers for the UART word scheduler.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    // MSB-first byte select; index 0 is bits [31:24].
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin arbiter: first eligible index at or after ptr+1, cyclic.
module uart_rr_arb #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         eligible,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] index,
    output logic                    any
);

    localparam int          IW = $clog2(NREQ);
    localparam int unsigned N  = NREQ;

    always_comb begin
        logic [IW-1:0] cand;
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand = IW'((32'(ptr) + off) % N);
            if (!any && eligible[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding 32-bit requester words to a byte UART, MSB first,
// with a per-byte completion timeout.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TMO  = 65535
) (
    input  logic                    uclk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         cfg_en,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*32-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_en,
    input  logic                    tx_done,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    tmo_err
);

    localparam int            IW        = $clog2(NREQ);
    localparam int            TW        = $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_C     = TW'(TMO);
    localparam logic [1:0]    LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [31:0]     word_q, word_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [IW-1:0]   gnt_id_q, gnt_id_d;
    logic [7:0]      tx_data_q, tx_data_d;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_index;
    logic            arb_any;
    logic [31:0]     req_word [NREQ];

    assign eligible = req_valid & cfg_en;

    uart_rr_arb #(.NREQ(NREQ)) u_arb (
        .eligible (eligible),
        .ptr      (ptr_q),
        .grant    (arb_grant),
        .index    (arb_index),
        .any      (arb_any)
    );

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_word[i] = req_data[32*i +: 32];
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        gnt_id_d   = gnt_id_q;
        tx_data_d  = tx_data_q;
        tmo_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    word_d     = req_word[arb_index];
                    gnt_id_d   = arb_index;
                    ptr_d      = arb_index;
                    byte_cnt_d = '0;
                    // tx_data is loaded on entry to SEND so it is valid alongside tx_en
                    tx_data_d  = word_byte(req_word[arb_index], 2'd0);
                    state_d    = SEND;
                end
            end
            SEND: begin
                tmo_cnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        tx_data_d  = word_byte(word_q, byte_cnt_q + 2'd1);
                        state_d    = SEND;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (tmo_cnt_d == TMO_C) begin
                        tmo_err = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge uclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= IW'(NREQ - 1);
            word_q     <= '0;
            byte_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            gnt_id_q   <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            gnt_id_q   <= gnt_id_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign req_ready = (rst_n && state_q == IDLE) ? arb_grant : '0;
    assign tx_en     = (state_q == SEND);
    assign tx_data   = tx_data_q;
    assign busy      = (state_q != IDLE);
    assign gnt_id    = gnt_id_q;

endmodule
